// File: rtl/spike_rate_decoder.sv
// Spike-line receive decoder: counts rising edges per WINDOW-cycle window, tracks the minimum
// inter-spike interval, and presents {rate, min_isi} on a valid/ready port with sticky overrun.
module spike_rate_decoder #(
  parameter int unsigned WINDOW = 256,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned ISI_W  = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             spike,
  output logic [CNT_W-1:0] rate,
  output logic [ISI_W-1:0] min_isi,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  output logic             busy
);

  localparam int unsigned WIN_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;

  typedef enum logic {
    IDLE,
    COUNT
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic             r_spike_q;
  logic [WIN_W-1:0] r_win_cnt;
  logic [CNT_W-1:0] r_edge_cnt;
  logic [ISI_W-1:0] r_isi_timer;
  logic [ISI_W-1:0] r_min_run;
  logic             r_have_prev;
  logic [CNT_W-1:0] r_rate;
  logic [ISI_W-1:0] r_min_isi;
  logic             r_out_valid;
  logic             r_overrun;

  logic             w_edge;
  logic             w_last;
  logic             w_new_result;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [ISI_W-1:0] w_min_nxt;
  logic [ISI_W-1:0] w_isi_inc;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (enable)  w_state_nxt = COUNT;
      COUNT:   if (!enable) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Final count/min of the current cycle, including an edge landing on it.
  always_comb begin
    w_edge       = spike & ~r_spike_q;
    w_last       = (r_win_cnt == WIN_W'(WINDOW - 1));
    w_new_result = (r_state == COUNT) && enable && w_last;
    w_cnt_nxt    = r_edge_cnt;
    if (w_edge && (r_edge_cnt != '1))
      w_cnt_nxt = r_edge_cnt + CNT_W'(1);
    w_min_nxt = r_min_run;
    if (w_edge && r_have_prev && (r_isi_timer < r_min_run))
      w_min_nxt = r_isi_timer;
    w_isi_inc = (r_isi_timer == '1) ? r_isi_timer : r_isi_timer + ISI_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_spike_q   <= 1'b0;
      r_win_cnt   <= '0;
      r_edge_cnt  <= '0;
      r_isi_timer <= '0;
      r_min_run   <= '1;
      r_have_prev <= 1'b0;
      r_rate      <= '0;
      r_min_isi   <= '1;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_spike_q <= spike;

      if (r_state == IDLE && enable) begin
        r_win_cnt   <= '0;
        r_edge_cnt  <= '0;
        r_min_run   <= '1;
        r_have_prev <= 1'b0;
        r_isi_timer <= '0;
      end else if (r_state == COUNT && enable) begin
        r_win_cnt  <= w_last ? '0 : r_win_cnt + WIN_W'(1);
        r_edge_cnt <= w_last ? '0 : w_cnt_nxt;
        r_min_run  <= w_last ? '1 : w_min_nxt;
        if (w_edge) begin
          r_isi_timer <= ISI_W'(1);
          r_have_prev <= 1'b1;
        end else begin
          r_isi_timer <= w_isi_inc;
        end
      end

      // A result arriving on an accept cycle replaces the accepted one without overrun.
      if (w_new_result) begin
        r_rate      <= w_cnt_nxt;
        r_min_isi   <= w_min_nxt;
        r_out_valid <= 1'b1;
        if (r_out_valid && !out_ready)
          r_overrun <= 1'b1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end

      if (!enable)
        r_overrun <= 1'b0;
    end
  end

  assign rate      = r_rate;
  assign min_isi   = r_min_isi;
  assign out_valid = r_out_valid;
  assign overrun   = r_overrun;
  assign busy      = (r_state == COUNT);

endmodule
